// File: rtl/test_result_reporter.sv
// test_result_reporter: write-only tohost slave that decodes test result
// writes, keeps saturating pass/fail counters and queues one record per
// result for the bench to drain.
// Optional watchdog: define REPORTER_TIMEOUT_EN to enable it.
module test_result_reporter #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          CNT_W          = 16,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_we_i,
  input  logic [31:0]      bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             bus_ready_o,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [31:0]      rec_data_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             all_pass_o,
  output logic             timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PASS = 2'b01;
  localparam logic [1:0] CMD_FAIL = 2'b10;
  localparam logic [1:0] CMD_END  = 2'b11;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             timeout_q, timeout_d;

  logic       hit;
  logic       accept;
  logic       push;
  logic       pop;
  logic [1:0] cmd;
  logic       wd_fire;

  assign cmd    = bus_wdata_i[31:30];
  assign hit    = bus_we_i && (bus_addr_i == TOHOST_ADDR);
  // Ready comes from the registered full flag, so a pop in the same cycle
  // does not open room for a push.
  assign accept = hit && !full_q;
  // Writes landing after DONE are acknowledged but leave no trace.
  assign push   = accept && (cmd != CMD_NOP) && (state_q != ST_DONE);
  assign pop    = (count_q != '0) && rec_ready_i;

  // Payload bits between the command field and the id carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{bus_wdata_i[29:16], (TIMEOUT_CYCLES == 0)};

`ifdef REPORTER_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;

  // Watchdog: counts idle cycles in RUN, restarts on every accepted write.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_fire  = 1'b0;
    if (state_q == ST_RUN) begin
      if (accept) begin
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (wd_cnt_d == 32'(TIMEOUT_CYCLES)) begin
          wd_fire = 1'b1;
        end
      end
    end else if (state_q == ST_IDLE) begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // FIFO pointer/occupancy bookkeeping; pointers wrap on the power-of-two depth.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d   = (count_d == (AW+1)'(FIFO_DEPTH));
  end

  // Saturating result counters; a watchdog expiry is scored as one failure.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (push && (cmd == CMD_PASS) && (pass_cnt_q != '1)) begin
      pass_cnt_d = pass_cnt_q + CNT_W'(1);
    end
    if (((push && (cmd == CMD_FAIL)) || wd_fire) && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  // Run-state sequencing: first result starts the run, end or watchdog stops it.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q | wd_fire;
    unique case (state_q)
      ST_IDLE: begin
        if (push && (cmd == CMD_END)) begin
          state_d = ST_DONE;
        end else if (push) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((push && (cmd == CMD_END)) || wd_fire) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  // Record storage; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd, 14'b0, bus_wdata_i[15:0]};
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= ST_IDLE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus_ready_o = !full_q;
  assign rec_valid_o = (count_q != '0);
  assign rec_data_o  = rec_valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign pass_cnt_o  = pass_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign state_o     = state_q;
  assign done_o      = (state_q == ST_DONE) && (count_q == '0);
  assign all_pass_o  = done_o && (fail_cnt_q == '0) && (pass_cnt_q != '0);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_test_result_reporter.sv
// Self-checking bench for test_result_reporter: directed scenarios plus
// random bus traffic, all compared against a queue-based reference model.
module tb_test_result_reporter;

  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam int DEPTH   = 8;
  localparam int CW      = 4;
  localparam int TIMEOUT = 50;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_we_i = 1'b0;
  logic [31:0]   bus_addr_i = '0;
  logic [31:0]   bus_wdata_i = '0;
  logic          bus_ready_o;
  logic          rec_valid_o;
  logic          rec_ready_i = 1'b0;
  logic [31:0]   rec_data_o;
  logic [CW-1:0] pass_cnt_o;
  logic [CW-1:0] fail_cnt_o;
  logic [1:0]    state_o;
  logic          done_o;
  logic          all_pass_o;
  logic          timeout_o;

  test_result_reporter #(
    .TOHOST_ADDR(TOHOST), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_ready_o(bus_ready_o),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_data_o(rec_data_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .state_o(state_o),
    .done_o(done_o), .all_pass_o(all_pass_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: record queue, plain integer counters, run phase 0/1/2.
  logic [31:0] m_q[$];
  int m_pass, m_fail, m_phase, m_timeout, m_idle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_phase = 0; m_timeout = 0; m_idle = 0;
  endtask

  task automatic compare_all();
    logic [31:0] head;
    logic        mdone;
    head  = (m_q.size() > 0) ? m_q[0] : 32'h0;
    mdone = (m_phase == 2) && (m_q.size() == 0);
    check_eq("bus_ready", 32'(bus_ready_o), 32'(m_q.size() < DEPTH));
    check_eq("rec_valid", 32'(rec_valid_o), 32'(m_q.size() > 0));
    check_eq("rec_data",  rec_data_o, head);
    check_eq("pass_cnt",  32'(pass_cnt_o), 32'(m_pass));
    check_eq("fail_cnt",  32'(fail_cnt_o), 32'(m_fail));
    check_eq("state",     32'(state_o), 32'(m_phase));
    check_eq("done",      32'(done_o), 32'(mdone));
    check_eq("all_pass",  32'(all_pass_o), 32'(mdone && m_fail == 0 && m_pass > 0));
    check_eq("timeout",   32'(timeout_o), 32'(m_timeout));
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic rdy, input logic r);
    logic [1:0] cmd;
    bit acc, pushed, popped, fire;
    bus_we_i = we; bus_addr_i = addr; bus_wdata_i = wdata; rec_ready_i = rdy; rst = r;
    cmd    = wdata[31:30];
    acc    = we && (addr == TOHOST) && (m_q.size() < DEPTH);
    popped = (m_q.size() > 0) && rdy;
    pushed = acc && (cmd != 2'b00) && (m_phase != 2);
    fire   = 1'b0;
`ifdef REPORTER_TIMEOUT_EN
    if (m_phase == 1) begin
      if (acc) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) fire = 1'b1;
      end
    end else if (m_phase == 0) m_idle = 0;
`endif
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (popped) void'(m_q.pop_front());
      if (pushed) m_q.push_back({cmd, 14'b0, wdata[15:0]});
      if (pushed && cmd == 2'b01 && m_pass < CMAX) m_pass++;
      if (((pushed && cmd == 2'b10) || fire) && m_fail < CMAX) m_fail++;
      if (fire) m_timeout = 1;
      if (m_phase != 2) begin
        if (pushed && cmd == 2'b11) m_phase = 2;
        else if (pushed && m_phase == 0) m_phase = 1;
        else if (fire) m_phase = 2;
      end
      if (acc) $display("write accepted: cmd=%0d id=%0d queued=%0d", cmd, wdata[15:0], m_q.size());
    end
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] wr(input logic [1:0] cmd, input int id);
    return {cmd, 14'b0, 16'(id)};
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_eq("reset_ready", 32'(bus_ready_o), 32'd1);
    check_eq("reset_state", 32'(state_o), 32'd0);

    // Three passes then end, draining continuously.
    for (int i = 1; i <= 3; i++) step(1'b1, TOHOST, wr(2'b01, i), 1'b1, 1'b0);
    step(1'b1, TOHOST, wr(2'b11, 0), 1'b1, 1'b0);
    idle(3, 1'b1);
    check_eq("t1_pass", 32'(pass_cnt_o), 32'd3);
    check_eq("t1_all_pass", 32'(all_pass_o), 32'd1);

    // Pass, fail, end with the drain stalled, then release.
    do_reset();
    step(1'b1, TOHOST, wr(2'b01, 5), 1'b0, 1'b0);
    step(1'b1, TOHOST, wr(2'b10, 6), 1'b0, 1'b0);
    step(1'b1, TOHOST, wr(2'b11, 0), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_eq("t2_fail_rec", rec_data_o, 32'h8000_0006);
    idle(4, 1'b1);
    check_eq("t2_fail", 32'(fail_cnt_o), 32'd1);
    check_eq("t2_all_pass", 32'(all_pass_o), 32'd0);

    // Back-pressure: nine passes into an eight-deep buffer.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, TOHOST, wr(2'b01, i), 1'b0, 1'b0);
    check_eq("t3_full", 32'(bus_ready_o), 32'd0);
    step(1'b1, TOHOST, wr(2'b01, 9), 1'b0, 1'b0);
    step(1'b1, TOHOST, wr(2'b01, 9), 1'b1, 1'b0);
    step(1'b1, TOHOST, wr(2'b01, 9), 1'b0, 1'b0);
    idle(10, 1'b1);
    check_eq("t3_pass", 32'(pass_cnt_o), 32'd9 & CMAX);

    // Misaddressed writes and no-op commands.
    do_reset();
    step(1'b1, TOHOST + 32'd4, wr(2'b01, 7), 1'b1, 1'b0);
    step(1'b1, TOHOST, wr(2'b00, 8), 1'b1, 1'b0);
    step(1'b1, TOHOST + 32'd4, wr(2'b11, 9), 1'b1, 1'b0);
    idle(2, 1'b1);
    check_eq("t4_state", 32'(state_o), 32'd0);

    // Reset with records queued mid-run.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, TOHOST, wr(2'b01, i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    check_eq("t5_valid", 32'(rec_valid_o), 32'd0);

`ifdef REPORTER_TIMEOUT_EN
    // Watchdog expiry after a single pass.
    do_reset();
    step(1'b1, TOHOST, wr(2'b01, 1), 1'b1, 1'b0);
    idle(TIMEOUT + 3, 1'b1);
    check_eq("t6_timeout", 32'(timeout_o), 32'd1);
`endif

    // Counter saturation and writes ignored after DONE.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, TOHOST, wr(2'b01, i), 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, TOHOST, wr(2'b10, i), 1'b1, 1'b0);
    step(1'b1, TOHOST, wr(2'b11, 0), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, TOHOST, wr(2'b01, i), 1'b1, 1'b0);
    check_eq("sat_pass", 32'(pass_cnt_o), 32'(CMAX));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  cmd;
      logic [31:0] addr;
      cmd  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 3) == 0) ? TOHOST + 32'd4 : TOHOST;
      step(1'($urandom_range(0, 1)), addr, {cmd, 14'($urandom), 16'($urandom)},
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
